// File: rtl/wishbone_arbiter_2m.sv
// Two-master Wishbone arbiter: alternating priority on ties, combinational pass-through
// for the owner, and a strobe-timeout that aborts a cycle the slave never acknowledges.
module wishbone_arbiter_2m #(
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  // master 0: instruction fetch
  input  logic                  i_m0_cyc,
  input  logic                  i_m0_stb,
  input  logic                  i_m0_we,
  input  logic [ADDR_WIDTH-1:0] i_m0_addr,
  input  logic [31:0]           i_m0_data,
  input  logic [3:0]            i_m0_sel,
  output logic                  o_m0_ack,
  output logic                  o_m0_err,
  output logic                  o_m0_stall,
  output logic [31:0]           o_m0_data,
  // master 1: load/store
  input  logic                  i_m1_cyc,
  input  logic                  i_m1_stb,
  input  logic                  i_m1_we,
  input  logic [ADDR_WIDTH-1:0] i_m1_addr,
  input  logic [31:0]           i_m1_data,
  input  logic [3:0]            i_m1_sel,
  output logic                  o_m1_ack,
  output logic                  o_m1_err,
  output logic                  o_m1_stall,
  output logic [31:0]           o_m1_data,
  // slave side
  output logic                  o_s_cyc,
  output logic                  o_s_stb,
  output logic                  o_s_we,
  output logic [ADDR_WIDTH-1:0] o_s_addr,
  output logic [31:0]           o_s_data,
  output logic [3:0]            o_s_sel,
  input  logic                  i_s_ack,
  input  logic                  i_s_stall,
  input  logic [31:0]           i_s_data,
  output logic [1:0]            o_grant
);

  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN_M0 = 2'd1,
    OWN_M1 = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [3:0]            sel_q;

  logic [1:0]            m_cyc, m_stb, m_we;
  logic [ADDR_WIDTH-1:0] m_addr  [2];
  logic [31:0]           m_wdata [2];
  logic [3:0]            m_sel   [2];
  logic [1:0]            m_ack, m_err, m_stall;
  logic [31:0]           m_rdata [2];

  logic own_any;
  logic sel_m;
  logic timeout_fire;

  assign m_cyc      = {i_m1_cyc, i_m0_cyc};
  assign m_stb      = {i_m1_stb, i_m0_stb};
  assign m_we       = {i_m1_we,  i_m0_we};
  assign m_addr[0]  = i_m0_addr;
  assign m_addr[1]  = i_m1_addr;
  assign m_wdata[0] = i_m0_data;
  assign m_wdata[1] = i_m1_data;
  assign m_sel[0]   = i_m0_sel;
  assign m_sel[1]   = i_m1_sel;

  assign own_any = (state_q != IDLE);
  assign sel_m   = (state_q == OWN_M1);
  assign o_grant = {state_q == OWN_M1, state_q == OWN_M0};

  // An ack arriving on the expiry cycle rescues the transfer.
  assign timeout_fire = own_any && (cnt_q >= TIMEOUT_C) && !i_s_ack;

  assign o_s_cyc  = own_any && m_cyc[sel_m] && !timeout_fire;
  assign o_s_stb  = own_any && m_stb[sel_m] && !timeout_fire;
  assign o_s_we   = own_any ? m_we[sel_m]    : we_q;
  assign o_s_addr = own_any ? m_addr[sel_m]  : addr_q;
  assign o_s_data = own_any ? m_wdata[sel_m] : wdata_q;
  assign o_s_sel  = own_any ? m_sel[sel_m]   : sel_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_master
      assign m_ack[gi]   = o_grant[gi] & i_s_ack;
      assign m_err[gi]   = o_grant[gi] & timeout_fire;
      assign m_stall[gi] = ~o_grant[gi] | i_s_stall;
      assign m_rdata[gi] = o_grant[gi] ? i_s_data : 32'd0;
    end
  endgenerate

  assign o_m0_ack   = m_ack[0];
  assign o_m0_err   = m_err[0];
  assign o_m0_stall = m_stall[0];
  assign o_m0_data  = m_rdata[0];
  assign o_m1_ack   = m_ack[1];
  assign o_m1_err   = m_err[1];
  assign o_m1_stall = m_stall[1];
  assign o_m1_data  = m_rdata[1];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (m_cyc[0] && m_cyc[1]) begin
          state_d      = last_grant_q ? OWN_M0 : OWN_M1;
          last_grant_d = ~last_grant_q;
        end else if (m_cyc[0]) begin
          state_d      = OWN_M0;
          last_grant_d = 1'b0;
        end else if (m_cyc[1]) begin
          state_d      = OWN_M1;
          last_grant_d = 1'b1;
        end
      end
      OWN_M0, OWN_M1: begin
        if (!m_cyc[sel_m] || timeout_fire) begin
          state_d = IDLE;
        end
        if (state_d != state_q || i_s_ack) begin
          cnt_d = '0;
        end else if (m_stb[sel_m] && cnt_q < TIMEOUT_C) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sel_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      // Remember what was last driven so the idle bus keeps it stable.
      we_q         <= o_s_we;
      addr_q       <= o_s_addr;
      wdata_q      <= o_s_data;
      sel_q        <= o_s_sel;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter_2m.sv
// Directed bench for wishbone_arbiter_2m: stimulus pushes expected master responses
// into a queue, a negedge monitor pops and compares every ack/err the DUT presents.
module tb_wishbone_arbiter_2m;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_m0_cyc, i_m0_stb, i_m0_we;
  logic [9:0]  i_m0_addr;
  logic [31:0] i_m0_data;
  logic [3:0]  i_m0_sel;
  logic        o_m0_ack, o_m0_err, o_m0_stall;
  logic [31:0] o_m0_data;
  logic        i_m1_cyc, i_m1_stb, i_m1_we;
  logic [9:0]  i_m1_addr;
  logic [31:0] i_m1_data;
  logic [3:0]  i_m1_sel;
  logic        o_m1_ack, o_m1_err, o_m1_stall;
  logic [31:0] o_m1_data;
  logic        o_s_cyc, o_s_stb, o_s_we;
  logic [9:0]  o_s_addr;
  logic [31:0] o_s_data;
  logic [3:0]  o_s_sel;
  logic        i_s_ack, i_s_stall;
  logic [31:0] i_s_data;
  logic [1:0]  o_grant;

  wishbone_arbiter_2m #(.ADDR_WIDTH(10), .TIMEOUT(15)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_cyc(i_m0_cyc), .i_m0_stb(i_m0_stb), .i_m0_we(i_m0_we),
    .i_m0_addr(i_m0_addr), .i_m0_data(i_m0_data), .i_m0_sel(i_m0_sel),
    .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err), .o_m0_stall(o_m0_stall), .o_m0_data(o_m0_data),
    .i_m1_cyc(i_m1_cyc), .i_m1_stb(i_m1_stb), .i_m1_we(i_m1_we),
    .i_m1_addr(i_m1_addr), .i_m1_data(i_m1_data), .i_m1_sel(i_m1_sel),
    .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err), .o_m1_stall(o_m1_stall), .o_m1_data(o_m1_data),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb), .o_s_we(o_s_we),
    .o_s_addr(o_s_addr), .o_s_data(o_s_data), .o_s_sel(o_s_sel),
    .i_s_ack(i_s_ack), .i_s_stall(i_s_stall), .i_s_data(i_s_data),
    .o_grant(o_grant)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          m;
    bit          err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic        mon_a, mon_e;
  logic [31:0] mon_d;
  exp_t        mon_x;

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      for (int m = 0; m < 2; m++) begin
        mon_a = (m == 1) ? o_m1_ack : o_m0_ack;
        mon_e = (m == 1) ? o_m1_err : o_m0_err;
        mon_d = (m == 1) ? o_m1_data : o_m0_data;
        if (mon_a || mon_e) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL sb_unexpected: m%0d ack=%b err=%b data=%h, required no response", m, mon_a, mon_e, mon_d);
          end else begin
            mon_x = exp_q.pop_front();
            if (mon_x.m != m || mon_x.err != mon_e || mon_x.err == mon_a || mon_d !== mon_x.data) begin
              n_bad++;
              $display("FAIL sb_response: got m%0d ack=%b err=%b data=%h, required m%0d err=%b data=%h",
                       m, mon_a, mon_e, mon_d, mon_x.m, mon_x.err, mon_x.data);
            end else begin
              $display("sb ok: m%0d %s data=%h", m, mon_e ? "err" : "ack", mon_d);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end else begin
      $display("ok %s: %h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic neg();
    @(negedge i_clk);
  endtask

  task automatic expect_rsp(input int m, input bit err, input logic [31:0] d);
    exp_q.push_back('{m, err, d});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    i_m0_cyc = 0; i_m0_stb = 0; i_m0_we = 0; i_m0_addr = '0; i_m0_data = '0; i_m0_sel = '0;
    i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0; i_m1_addr = '0; i_m1_data = '0; i_m1_sel = '0;
    i_s_ack = 0; i_s_stall = 0; i_s_data = '0;

    // reset state
    neg(); neg();
    chk("rst_grant", o_grant, 2'b00);
    chk("rst_s_cyc", o_s_cyc, 1'b0);
    chk("rst_s_stb", o_s_stb, 1'b0);
    chk("rst_m0_stall", o_m0_stall, 1'b1);
    chk("rst_m1_stall", o_m1_stall, 1'b1);
    chk("rst_m0_ack", o_m0_ack, 1'b0);
    chk("rst_m0_err", o_m0_err, 1'b0);
    tick();
    i_rst_n = 1;

    // tie after reset: m0 first, one idle cycle, then m1, next tie m0 again
    i_m0_cyc = 1; i_m1_cyc = 1;
    neg();  chk("tie_wait", o_grant, 2'b00);
    tick(); neg();
    chk("tie_first_m0", o_grant, 2'b01);
    chk("tie_s_cyc", o_s_cyc, 1'b1);
    i_m0_cyc = 0;
    tick(); neg(); chk("tie_idle_gap", o_grant, 2'b00);
    tick(); neg(); chk("tie_then_m1", o_grant, 2'b10);
    i_m1_cyc = 0;
    tick(); neg(); chk("tie_m1_release", o_grant, 2'b00);
    i_m0_cyc = 1; i_m1_cyc = 1;
    tick(); neg(); chk("tie_second_m0", o_grant, 2'b01);
    i_m0_cyc = 0; i_m1_cyc = 0;
    tick(); neg(); chk("tie_done_idle", o_grant, 2'b00);

    // single master read
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_we = 0; i_m0_addr = 10'h004; i_m0_sel = 4'hF;
    #1;
    chk("rd_pre_grant_stall", o_m0_stall, 1'b1);
    chk("rd_pre_grant_cyc", o_s_cyc, 1'b0);
    tick(); neg();
    chk("rd_grant_latency", o_s_cyc, 1'b1);
    chk("rd_s_stb", o_s_stb, 1'b1);
    chk("rd_s_addr", o_s_addr, 10'h004);
    chk("rd_m1_stall", o_m1_stall, 1'b1);
    tick();
    i_s_ack = 1; i_s_data = 32'h00c00193;
    expect_rsp(0, 1'b0, 32'h00c00193);
    neg();
    chk("rd_m1_stall_ack", o_m1_stall, 1'b1);
    chk("rd_m1_no_ack", o_m1_ack, 1'b0);
    tick();
    i_s_ack = 0; i_s_data = '0; i_m0_cyc = 0; i_m0_stb = 0;
    tick(); neg();
    chk("rd_idle_grant", o_grant, 2'b00);
    chk("rd_idle_cyc", o_s_cyc, 1'b0);
    chk("rd_idle_hold_addr", o_s_addr, 10'h004);
    #1 i_s_ack = 1;
    #1;
    chk("idle_ack_m0", o_m0_ack, 1'b0);
    chk("idle_ack_m1", o_m1_ack, 1'b0);
    i_s_ack = 0;

    // m1 write pass-through
    tick();
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_we = 1; i_m1_addr = 10'h054; i_m1_data = 32'h0000000C; i_m1_sel = 4'hF;
    tick();
    i_s_ack = 1; i_s_data = 32'hA5A50001;
    expect_rsp(1, 1'b0, 32'hA5A50001);
    neg();
    chk("wr_grant", o_grant, 2'b10);
    chk("wr_s_we", o_s_we, 1'b1);
    chk("wr_s_addr", o_s_addr, 10'h054);
    chk("wr_s_data", o_s_data, 32'h0000000C);
    chk("wr_s_sel", o_s_sel, 4'hF);
    chk("wr_ack_same_cycle", o_m1_ack, 1'b1);
    chk("wr_m0_stall", o_m0_stall, 1'b1);
    tick();
    i_s_ack = 0; i_s_data = '0; i_m1_cyc = 0; i_m1_stb = 0; i_m1_we = 0;
    tick(); neg(); chk("wr_idle", o_grant, 2'b00);

    // timeout on m0 with m1 pending
    i_m0_cyc = 1; i_m0_stb = 1; i_m0_addr = 10'h008;
    i_m1_cyc = 1; i_m1_stb = 1; i_m1_addr = 10'h010;
    tick(); neg(); chk("to_owner_m0", o_grant, 2'b01);
    repeat (14) tick();
    neg(); chk("to_not_early", o_m0_err, 1'b0);
    tick();
    expect_rsp(0, 1'b1, 32'd0);
    neg();
    chk("to_err_pulse", o_m0_err, 1'b1);
    chk("to_s_cyc_low", o_s_cyc, 1'b0);
    chk("to_s_stb_low", o_s_stb, 1'b0);
    chk("to_no_ack", o_m0_ack, 1'b0);
    i_m0_cyc = 0; i_m0_stb = 0;
    tick(); neg();
    chk("to_idle", o_grant, 2'b00);
    chk("to_err_one_cycle", o_m0_err, 1'b0);
    tick(); neg(); chk("to_pending_m1", o_grant, 2'b10);

    // asynchronous reset while m1 owns with stb high
    #2 i_rst_n = 0;
    #1;
    chk("arst_s_cyc", o_s_cyc, 1'b0);
    chk("arst_grant", o_grant, 2'b00);
    chk("arst_m1_err", o_m1_err, 1'b0);
    chk("arst_m1_stall", o_m1_stall, 1'b1);
    i_s_ack = 1;
    #1 chk("arst_m1_no_ack", o_m1_ack, 1'b0);
    i_m1_cyc = 0; i_m1_stb = 0;
    tick(); tick(); neg();
    chk("arst_held_grant", o_grant, 2'b00);
    i_s_ack = 0;
    tick();
    i_rst_n = 1;

    // after reset the tie goes to m0 again; then ack collides with timeout
    i_m0_cyc = 1; i_m1_cyc = 1;
    tick(); neg(); chk("post_rst_tie_m0", o_grant, 2'b01);
    i_m1_cyc = 0; i_m0_stb = 1; i_m0_addr = 10'h00C;
    repeat (15) tick();
    i_s_ack = 1; i_s_data = 32'h12345678;
    expect_rsp(0, 1'b0, 32'h12345678);
    neg();
    chk("col_no_err", o_m0_err, 1'b0);
    chk("col_ack", o_m0_ack, 1'b1);
    chk("col_s_cyc", o_s_cyc, 1'b1);
    tick();
    i_s_ack = 0; i_s_data = '0;
    neg();
    chk("col_grant_kept", o_grant, 2'b01);
    chk("col_err_after", o_m0_err, 1'b0);
    i_m0_cyc = 0; i_m0_stb = 0;
    tick(); tick(); neg();
    chk("end_idle", o_grant, 2'b00);
    chk("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
